// File: rtl/aes_cmd_queue.sv
// aes_cmd_queue: command FIFO and single-issue FSM in front of the AES core.
// Define AES_CMDQ_TIMEOUT_EN to add the 8-bit WAIT watchdog.
package aes_pkg;
   typedef enum logic [2:0] {
      NOOP            = 3'd0,
      AESENC          = 3'd1,
      AESENCLAST      = 3'd2,
      AESDEC          = 3'd3,
      AESDECLAST      = 3'd4,
      AESIMC          = 3'd5,
      AESKEYGENASSIST = 3'd6
   } opcode;
endpackage

module aes_cmd_queue
   import aes_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  opcode            cmd_opcode_i,
   input  logic [127:0]     cmd_data_i,
   input  logic [127:0]     cmd_key_i,
   input  logic [TAG_W-1:0] cmd_tag_i,
   input  logic             flush_i,
   output logic             start_o,
   output opcode            opcode_o,
   output logic [127:0]     data_o,
   output logic [127:0]     key_o,
   input  logic             busy_i,
   input  logic             cipher_ready_i,
   input  logic             key_ready_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic             rsp_is_key_o,
   output logic             rsp_err_o,
   output logic [7:0]       drop_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      opcode            op;
      logic [127:0]     data;
      logic [127:0]     key;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   entry_t        mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          accept;
   logic          push;
   logic          drop;
   logic          pop;
   logic          core_done;
   logic          wd_hit;
   logic          to_resp;

   assign full        = (count == FULL_CNT);
   assign empty       = (count == '0);
   assign cmd_ready_o = !full && !flush_i;
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign push        = accept && (cmd_opcode_i != NOOP);
   assign drop        = accept && (cmd_opcode_i == NOOP);
   assign pop         = (state == IDLE) && !empty && !busy_i && !flush_i;
   assign core_done   = cipher_ready_i || key_ready_i;
   assign to_resp     = (state == WAIT) && (state_nxt == RESP);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush_i) begin
         rptr  <= wptr;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= '{op: cmd_opcode_i, data: cmd_data_i,
                        key: cmd_key_i, tag: cmd_tag_i};
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         drop_cnt_o <= '0;
      end else if (drop && (drop_cnt_o != 8'hFF)) begin
         drop_cnt_o <= drop_cnt_o + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pop) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (core_done || wd_hit) state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // start_o is registered off ISSUE, so it rises with the entry into WAIT
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state        <= IDLE;
         start_o      <= 1'b0;
         opcode_o     <= NOOP;
         data_o       <= '0;
         key_o        <= '0;
         rsp_tag_o    <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_is_key_o <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_o <= (state == ISSUE);
         if (pop) begin
            opcode_o  <= mem[rptr].op;
            data_o    <= mem[rptr].data;
            key_o     <= mem[rptr].key;
            rsp_tag_o <= mem[rptr].tag;
         end
         if (to_resp) begin
            rsp_valid_o  <= 1'b1;
            rsp_is_key_o <= key_ready_i;
         end else if ((state == RESP) && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
         end
      end
   end

`ifdef AES_CMDQ_TIMEOUT_EN
   logic [7:0] wdog;
   logic       err_q;

   // cleared while in ISSUE so it reads zero on the first WAIT cycle
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wdog <= '0;
      end else if (state == ISSUE) begin
         wdog <= '0;
      end else if ((state == WAIT) && !wd_hit) begin
         wdog <= wdog + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         err_q <= 1'b0;
      end else if (to_resp) begin
         err_q <= !core_done;
      end
   end

   assign wd_hit    = (wdog == 8'hFF);
   assign rsp_err_o = err_q;
`else
   assign wd_hit    = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_cmd_queue.sv
// tb_aes_cmd_queue: directed stimulus with a scoreboard checking
// issued operands and returned responses against queued expectations.
`timescale 1ns/1ps
module tb_aes_cmd_queue;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   opcode        cmd_op = NOOP;
   logic [127:0] cmd_data = '0;
   logic [127:0] cmd_key = '0;
   logic [3:0]   cmd_tag = '0;
   logic         flush = 1'b0;
   logic         start;
   opcode        op_out;
   logic [127:0] data_out;
   logic [127:0] key_out;
   logic         busy = 1'b0;
   logic         cipher_ready;
   logic         key_ready;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [3:0]   rsp_tag;
   logic         rsp_is_key;
   logic         rsp_err;
   logic [7:0]   drop_cnt;

   typedef struct {
      opcode        op;
      logic [127:0] data;
      logic [127:0] key;
   } st_t;

   typedef struct {
      logic [3:0] tag;
      logic       is_key;
      logic       err;
   } rs_t;

   st_t exp_st[$];
   rs_t exp_rs[$];
   st_t es;
   rs_t er;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_start = 0;
   int n_rsp = 0;
   int start_cyc = 0;
   int rdy_cyc = 0;
   int rsp_rise = 0;
   int push_cyc = 0;
   logic prev_v = 1'b0;
   int core_mode = 0;
   int core_delay = 4;

   aes_cmd_queue #(.DEPTH(4), .TAG_W(4)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_opcode_i  (cmd_op),
      .cmd_data_i    (cmd_data),
      .cmd_key_i     (cmd_key),
      .cmd_tag_i     (cmd_tag),
      .flush_i       (flush),
      .start_o       (start),
      .opcode_o      (op_out),
      .data_o        (data_out),
      .key_o         (key_out),
      .busy_i        (busy),
      .cipher_ready_i(cipher_ready),
      .key_ready_i   (key_ready),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_tag_o     (rsp_tag),
      .rsp_is_key_o  (rsp_is_key),
      .rsp_err_o     (rsp_err),
      .drop_cnt_o    (drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // core model: mode 0 cipher ready, mode 1 both readies, mode 2 never
   initial begin
      cipher_ready = 1'b0;
      key_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (start && core_mode != 2) begin
            repeat (core_delay) @(posedge clk);
            #1;
            cipher_ready = 1'b1;
            key_ready = (core_mode == 1);
            @(posedge clk); #1;
            cipher_ready = 1'b0;
            key_ready = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (nrst) begin
         if (cipher_ready || key_ready) rdy_cyc = cyc;
         if (rsp_valid && !prev_v) rsp_rise = cyc;
         prev_v = rsp_valid;
         if (start) begin
            start_cyc = cyc;
            n_start++;
            if (exp_st.size() == 0) begin
               chk("start_unexpected", start, 1'b0);
            end else begin
               es = exp_st.pop_front();
               chk("start_op", op_out, es.op);
               chk("start_data", data_out, es.data);
               chk("start_key", key_out, es.key);
            end
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_rs.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
               er = exp_rs.pop_front();
               chk("rsp_tag", rsp_tag, er.tag);
               chk("rsp_is_key", rsp_is_key, er.is_key);
               chk("rsp_err", rsp_err, er.err);
            end
         end
      end else begin
         prev_v = 1'b0;
      end
   end

   task automatic push(input opcode op, input logic [3:0] tag,
                       input logic is_key, input logic err, input bit expect_it);
      int t;
      logic [127:0] d;
      logic [127:0] k;
      d = 128'h00112233_44556677_8899aabb_ccddee00 + 128'(tag);
      k = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e00 + 128'(tag);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_tag = tag;
      cmd_data = d;
      cmd_key = k;
      t = 0;
      while (!cmd_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (!cmd_ready) begin
         chk("push_timeout", cmd_ready, 1'b1);
         cmd_valid = 1'b0;
         return;
      end
      if (op != NOOP && expect_it) begin
         exp_st.push_back('{op, d, k});
         exp_rs.push_back('{tag, is_key, err});
      end
      @(posedge clk); #1;
      push_cyc = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input int max_cyc);
      int t;
      t = 0;
      while (n_rsp < target && t < max_cyc) begin
         @(posedge clk); #1;
         t++;
      end
      chk("rsp_arrived", 128'(n_rsp >= target), 1'b1);
   endtask

   task automatic wait_start(input int s0);
      int t;
      t = 0;
      while (n_start <= s0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("start_arrived", 128'(n_start > s0), 1'b1);
   endtask

   int s0;
   int n0;
   int p0;
   int acc;
   int t;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start", start, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_is_key", rsp_is_key, 1'b0);
      chk("rst_err", rsp_err, 1'b0);
      chk("rst_drop", drop_cnt, 8'd0);
      chk("rst_op", op_out, NOOP);
      chk("rst_data", data_out, 128'd0);
      chk("rst_key", key_out, 128'd0);
      chk("rst_tag", rsp_tag, 4'd0);
      nrst = 1'b1;
      chk("rst_rel_ready", cmd_ready, 1'b1);
      @(posedge clk); #1;

      // single AESENC, latency
      s0 = n_start;
      n0 = n_rsp;
      push(AESENC, 4'd3, 1'b0, 1'b0, 1'b1);
      p0 = push_cyc;
      wait_rsp(n0 + 1, 50);
      chk("lat_start", 128'(start_cyc - p0), 128'd2);
      chk("lat_rsp", 128'(rsp_rise - rdy_cyc), 128'd1);
      chk("one_start", 128'(n_start - s0), 128'd1);

      // fill with core busy
      busy = 1'b1;
      core_delay = 2;
      n0 = n_rsp;
      for (int i = 1; i <= 4; i++) push(AESENC, 4'(i), 1'b0, 1'b0, 1'b1);
      chk("full_ready", cmd_ready, 1'b0);
      cmd_valid = 1'b1;
      cmd_op = AESDEC;
      acc = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (cmd_ready) acc++;
      end
      chk("stall_ready", 128'(acc), 128'd0);
      busy = 1'b0;
      push(AESDEC, 4'd5, 1'b0, 1'b0, 1'b1);
      wait_rsp(n0 + 5, 300);

      // NOOP drops saturate
      s0 = n_start;
      for (int i = 0; i < 300; i++) begin
         push(NOOP, 4'd0, 1'b0, 1'b0, 1'b0);
         if (i == 99) chk("drop_100", drop_cnt, 8'd100);
      end
      chk("drop_sat", drop_cnt, 8'd255);
      chk("noop_no_start", 128'(n_start - s0), 128'd0);

      // flush while first is in WAIT
      core_delay = 6;
      s0 = n_start;
      n0 = n_rsp;
      push(AESENC, 4'd10, 1'b0, 1'b0, 1'b1);
      push(AESENCLAST, 4'd11, 1'b0, 1'b0, 1'b0);
      push(AESDECLAST, 4'd12, 1'b0, 1'b0, 1'b0);
      wait_start(s0);
      flush = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = AESDEC;
      cmd_tag = 4'd7;
      #1;
      chk("flush_ready", cmd_ready, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0;
      cmd_valid = 1'b0;
      wait_rsp(n0 + 1, 50);
      repeat (12) @(posedge clk);
      #1;
      chk("flush_one_rsp", 128'(n_rsp - n0), 128'd1);
      chk("flush_one_start", 128'(n_start - s0), 128'd1);
      push(AESDEC, 4'd6, 1'b0, 1'b0, 1'b1);
      wait_rsp(n0 + 2, 50);

      // key priority and response hold
      core_mode = 1;
      rsp_ready = 1'b0;
      n0 = n_rsp;
      push(AESKEYGENASSIST, 4'd9, 1'b1, 1'b0, 1'b1);
      t = 0;
      while (!rsp_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("key_rsp_seen", rsp_valid, 1'b1);
      repeat (6) begin
         @(posedge clk); #1;
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_tag", rsp_tag, 4'd9);
         chk("hold_is_key", rsp_is_key, 1'b1);
      end
      rsp_ready = 1'b1;
      wait_rsp(n0 + 1, 20);

`ifdef AES_CMDQ_TIMEOUT_EN
      core_mode = 2;
      n0 = n_rsp;
      push(AESENC, 4'd2, 1'b0, 1'b1, 1'b1);
      wait_rsp(n0 + 1, 400);
      chk("wd_latency", 128'(rsp_rise - start_cyc), 128'd256);
`endif

      // reset mid-WAIT abandons the command
      core_mode = 2;
      s0 = n_start;
      n0 = n_rsp;
      push(AESENC, 4'd5, 1'b0, 1'b0, 1'b1);
      wait_start(s0);
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b0;
      @(posedge clk); #1;
      exp_rs.delete();
      chk("mrst_start", start, 1'b0);
      chk("mrst_rsp_valid", rsp_valid, 1'b0);
      chk("mrst_is_key", rsp_is_key, 1'b0);
      chk("mrst_err", rsp_err, 1'b0);
      chk("mrst_drop", drop_cnt, 8'd0);
      chk("mrst_op", op_out, NOOP);
      chk("mrst_data", data_out, 128'd0);
      chk("mrst_key", key_out, 128'd0);
      chk("mrst_tag", rsp_tag, 4'd0);
      nrst = 1'b1;
      chk("mrst_ready", cmd_ready, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      chk("mrst_no_rsp", 128'(n_rsp - n0), 128'd0);
      chk("mrst_valid_low", rsp_valid, 1'b0);

      chk("exp_st_empty", 128'(exp_st.size()), 128'd0);
      chk("exp_rs_empty", 128'(exp_rs.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aes_cmd_queue.md
AES_CMD_QUEUE -- requirements
Module: aes_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter TAG_W, default 4, width of the user tag carried with each command.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 nrst  in  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 cmd_valid_i  in  1  upstream command valid.
REQ-006 cmd_ready_o  out  1  queue can accept a command.
REQ-007 cmd_opcode_i  in  aes_pkg::opcode  requested operation.
REQ-008 cmd_data_i / cmd_key_i  in  128 each  state word / round key.
REQ-009 cmd_tag_i  in  TAG_W  user tag, returned with the response.
REQ-010 flush_i  in  1  discard all queued, not-yet-issued commands.
REQ-011 start_o  out  1  one-cycle start pulse to the AES control core.
REQ-012 opcode_o  out  aes_pkg::opcode  opcode presented with start_o.
REQ-013 data_o / key_o  out  128 each  operands, held stable from start_o until response.
REQ-014 busy_i, cipher_ready_i, key_ready_i  in  1 each  status from the AES control core.
REQ-015 rsp_valid_o  out  1  response valid.
REQ-016 rsp_ready_i  in  1  downstream accepts the response.
REQ-017 rsp_tag_o  out  TAG_W  tag of the completed command.
REQ-018 rsp_is_key_o / rsp_err_o  out  1 each  key-generation completion / timeout completion.
REQ-019 drop_cnt_o  out  8  count of NOOP commands discarded.

Function
REQ-020 The queue SHALL accept a command when cmd_valid_i and cmd_ready_o are both high on a clk edge; cmd_ready_o SHALL equal "FIFO not full", with no same-cycle pass-through.
REQ-021 An accepted NOOP SHALL NOT be enqueued; it SHALL increment drop_cnt_o, which saturates at 255.
REQ-022 A simultaneous push and pop SHALL leave the occupancy unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-023 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-024 IDLE -> ISSUE when the FIFO is not empty and busy_i is low; the head entry SHALL be popped into the operand registers on that edge.
REQ-025 ISSUE SHALL assert start_o for exactly one cycle, then go to WAIT.
REQ-026 WAIT -> RESP on cipher_ready_i or key_ready_i; rsp_is_key_o SHALL equal key_ready_i captured on that edge.
REQ-027 If cipher_ready_i and key_ready_i are high together, key_ready_i SHALL take priority.
REQ-028 RESP SHALL hold rsp_valid_o and the response fields stable until rsp_ready_i is high, then go to IDLE.
REQ-029 Latency from a push into an empty queue with the core idle and rsp_ready_i high SHALL be: start_o 2 cycles after the push edge, and rsp_valid_o 1 cycle after the core's ready pulse.
REQ-030 At most one command SHALL be in flight.
REQ-031 flush_i SHALL empty the FIFO on the next edge; any command in ISSUE, WAIT or RESP SHALL complete normally.
REQ-032 A push in the same cycle as flush_i SHALL be discarded; cmd_ready_o SHALL be low while flush_i is high.
REQ-033 The queue SHALL ignore cipher_ready_i and key_ready_i outside WAIT.

Reset
REQ-034 While nrst is low at a clk edge, the queue SHALL:
- enter IDLE;
- empty the FIFO and zero both pointers;
- set start_o = 0, rsp_valid_o = 0, rsp_is_key_o = 0, rsp_err_o = 0, drop_cnt_o = 0;
- set opcode_o = NOOP;
- zero data_o, key_o and rsp_tag_o.
REQ-035 A reset asserted mid-operation SHALL abandon the in-flight command with no response; cmd_ready_o SHALL be high on the first cycle after reset release.

Configuration
REQ-036 Macro AES_CMDQ_TIMEOUT_EN, when defined, SHALL add an 8-bit watchdog that clears on entering WAIT and increments each WAIT cycle.
REQ-037 When the watchdog reaches 255, the FSM SHALL go to RESP with rsp_err_o = 1 and rsp_is_key_o = 0.
REQ-038 When the watchdog is not defined, WAIT SHALL have no exit except core ready or reset, and rsp_err_o SHALL be tied to 0.

Verification
REQ-039 Push an AESENC, tag 3, into an idle queue, with a core model giving cipher_ready 4 cycles after start -> one start_o pulse with opcode_o = AESENC, then rsp_valid_o with rsp_tag_o = 3, rsp_is_key_o = 0.
REQ-040 Push 5 commands back-to-back at DEPTH = 4 with the core stalled busy -> cmd_ready_o low after the 4th; the 5th is accepted only after the first pop; responses arrive in tag order.
REQ-041 Push NOOP 300 times -> no start_o pulse, and drop_cnt_o = 255.
REQ-042 Queue 3 commands, assert flush_i while the first is in WAIT -> exactly one response, then the FIFO is empty and the queue returns to IDLE.
REQ-043 Drive key_ready_i and cipher_ready_i in the same cycle for an AESKEYGENASSIST, tag 9 -> rsp_is_key_o = 1, rsp_tag_o = 9; hold rsp_ready_i low 6 cycles -> response stays stable.
REQ-044 With AES_CMDQ_TIMEOUT_EN defined and the core never ready -> rsp_err_o = 1 exactly 256 cycles after entering WAIT; then assert nrst mid-WAIT on a second command -> no response, all outputs at reset values.
